// File: rtl/sort_frame_loader.sv
// sort_frame_loader: decodes length-prefixed UART frames into little-endian elements
// and hands them to the sort core over valid/ready.
module sort_frame_loader #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_ELEMS = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic [DATA_WIDTH-1:0] elem_data_o,
  output logic                  elem_valid_o,
  output logic                  elem_last_o,
  input  logic                  elem_ready_i,
  output logic                  busy_o,
  output logic                  frame_err_o
);
  localparam int BPE = (DATA_WIDTH + 7) / 8;
  localparam int CW = $clog2(BPE + 1);
  localparam logic [CW-1:0] LAST_B = CW'(BPE - 1);
  localparam logic [7:0] MAX_N = 8'(MAX_ELEMS);
  typedef enum logic [1:0] {IDLE, ASSEMBLE, EMIT} state_t;
  state_t state, state_n;
  logic [7:0] rem, rem_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_WIDTH-1:0] acc, acc_n;
  logic last_n, err_n, take;
  assign take = rx_valid_i & rx_ready_o;
  assign elem_data_o = acc;
  always_comb begin
    state_n = state;
    rem_n = rem;
    cnt_n = cnt;
    acc_n = acc;
    last_n = elem_last_o;
    err_n = 1'b0;
    case (state)
      IDLE: if (take) begin
        if (rx_data_i == 8'd0 || rx_data_i > MAX_N) err_n = 1'b1;
        else begin
          rem_n = rx_data_i;
          cnt_n = '0;
          state_n = ASSEMBLE;
        end
      end
      ASSEMBLE: if (take) begin
        // first byte of each element wipes the previous element's bits
        acc_n = cnt == '0 ? '0 : acc;
        for (int i = 0; i < DATA_WIDTH; i++)
          if (cnt == CW'(i / 8)) acc_n[i] = rx_data_i[i % 8];
        cnt_n = cnt + 1'b1;
        if (cnt == LAST_B) begin
          state_n = EMIT;
          last_n = rem == 8'd1;
        end
      end
      EMIT: if (elem_ready_i) begin
        rem_n = rem - 8'd1;
        cnt_n = '0;
        last_n = 1'b0;
        state_n = elem_last_o ? IDLE : ASSEMBLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      rem <= '0;
      cnt <= '0;
      acc <= '0;
      elem_last_o <= 1'b0;
      elem_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
      rx_ready_o <= 1'b1;
      busy_o <= 1'b0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      cnt <= cnt_n;
      acc <= acc_n;
      elem_last_o <= last_n;
      elem_valid_o <= state_n == EMIT;
      frame_err_o <= err_n;
      rx_ready_o <= state_n != EMIT;
      busy_o <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_sort_frame_loader.sv
// tb_sort_frame_loader: random and directed frames checked against a byte-stream parser model.
module tb_sort_frame_loader;
  localparam int DW = 16;
  localparam int MAXE = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0, rx_ready, elem_valid, elem_last, elem_ready, busy, frame_err;
  logic [DW-1:0] elem_data;
  logic [7:0] rx_data12 = '0;
  logic rx_valid12 = 1'b0, rx_ready12, elem_valid12, elem_last12, busy12, err12;
  logic [11:0] elem_data12;
  int bp_mode = 0;
  int checks = 0, failures = 0;
  byte unsigned sent[$];
  logic [DW:0] got[$];
  int got_err = 0;
  logic hold = 1'b0;
  logic [DW:0] held;

  sort_frame_loader #(.DATA_WIDTH(DW), .MAX_ELEMS(MAXE)) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .elem_data_o(elem_data), .elem_valid_o(elem_valid), .elem_last_o(elem_last),
    .elem_ready_i(elem_ready), .busy_o(busy), .frame_err_o(frame_err));

  sort_frame_loader #(.DATA_WIDTH(12), .MAX_ELEMS(MAXE)) u12 (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data12), .rx_valid_i(rx_valid12), .rx_ready_o(rx_ready12),
    .elem_data_o(elem_data12), .elem_valid_o(elem_valid12), .elem_last_o(elem_last12),
    .elem_ready_i(1'b1), .busy_o(busy12), .frame_err_o(err12));

  always #5 clk = ~clk;

  always @(negedge clk)
    elem_ready = bp_mode == 0 ? 1'b1 : bp_mode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;

  // transfer monitor: collects accepted elements, counts error cycles, checks stalled outputs hold
  always @(negedge clk) begin
    #1;
    if (rst) hold = 1'b0;
    else begin
      if (hold) begin
        checks++;
        if (!elem_valid || {elem_last, elem_data} !== held) begin
          failures++;
          $display("FAIL hold_stable got valid=%b elem=%h want valid=1 elem=%h", elem_valid, {elem_last, elem_data}, held);
        end
      end
      if (elem_valid && elem_ready) got.push_back({elem_last, elem_data});
      if (frame_err) got_err++;
      hold = elem_valid && !elem_ready;
      held = {elem_last, elem_data};
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      failures++;
      $display("FAIL send_timeout byte=%h rx_ready=%b want 1", b, rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    sent.push_back(b);
  endtask

  task automatic clear_stream();
    sent.delete();
    got.delete();
    got_err = 0;
  endtask

  task automatic check_stream(input string name);
    logic [DW:0] exp_q[$];
    int exp_err = 0, i = 0, h, n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_ready !== 1'b1 || elem_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle busy=%b rx_ready=%b valid=%b want 0 1 0", name, busy, rx_ready, elem_valid);
    end
    while (i < sent.size()) begin
      h = sent[i];
      i++;
      if (h == 0 || h > MAXE) exp_err++;
      else for (int e = 0; e < h; e++) begin
        exp_q.push_back({1'(e == h - 1), sent[i+1], sent[i]});
        i += 2;
      end
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_count got=%0d want=%0d", name, got.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_q[k]) begin
        failures++;
        $display("FAIL %s_elem[%0d] got=%h want=%h", name, k, got[k], exp_q[k]);
      end
    end
    checks++;
    if (got_err != exp_err) begin
      failures++;
      $display("FAIL %s_errs got=%0d want=%0d", name, got_err, exp_err);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_ready, elem_valid, elem_last, busy, frame_err, elem_data} !== {5'b10000, 16'h0}) begin
      failures++;
      $display("FAIL reset_values got=%h want=%h", {rx_ready, elem_valid, elem_last, busy, frame_err, elem_data}, {5'b10000, 16'h0});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({rx_ready, busy} !== 2'b10) begin
      failures++;
      $display("FAIL reset_release got rdy/busy=%b want 10", {rx_ready, busy});
    end
  endtask

  task automatic test_single();
    clear_stream();
    send(8'h02); send(8'h34); send(8'h12); send(8'hCD); send(8'hAB);
    check_stream("single");
    checks++;
    if (got.size() != 2 || got[0] !== 17'h01234 || got[1] !== 17'h1ABCD) begin
      failures++;
      $display("FAIL single_fixed got size=%0d want elements 01234,1abcd", got.size());
    end
  endtask

  task automatic test_bad_headers();
    clear_stream();
    send(8'h00);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_hdr_idle busy=%b want 0", busy);
    end
    send(8'h11);
    send(8'h01); send(8'hFF); send(8'h00);
    check_stream("bad_hdr");
  endtask

  task automatic test_backpressure();
    clear_stream();
    bp_mode = 2;
    send(8'h02); send(8'h11); send(8'h22);
    rx_data = 8'h44;
    rx_valid = 1'b1;
    repeat (5) begin
      checks++;
      if (rx_ready !== 1'b0 || elem_valid !== 1'b1 || elem_data !== 16'h2211) begin
        failures++;
        $display("FAIL bp_stall rdy=%b valid=%b data=%h want 0 1 2211", rx_ready, elem_valid, elem_data);
      end
      @(negedge clk);
    end
    bp_mode = 0;
    send(8'h44); send(8'h33);
    check_stream("bp");
  endtask

  task automatic test_max();
    clear_stream();
    send(8'h10);
    for (int e = 0; e < 16; e++) begin
      send(8'(e));
      send(8'h00);
    end
    check_stream("max");
  endtask

  task automatic test_random();
    int h;
    clear_stream();
    bp_mode = 1;
    repeat (8) begin
      h = $urandom_range(0, 18);
      send(8'(h));
      if (h >= 1 && h <= MAXE) repeat (2 * h) send(8'($urandom));
    end
    check_stream("random");
    bp_mode = 0;
  endtask

  task automatic test_reset_mid();
    clear_stream();
    send(8'h03); send(8'h55);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rx_ready, elem_valid, elem_last, busy, frame_err, elem_data} !== {5'b10000, 16'h0}) begin
      failures++;
      $display("FAIL reset_mid got=%h want=%h", {rx_ready, elem_valid, elem_last, busy, frame_err, elem_data}, {5'b10000, 16'h0});
    end
    @(negedge clk);
    rst = 1'b0;
    clear_stream();
    send(8'h01); send(8'h22); send(8'h11);
    check_stream("after_reset");
    checks++;
    if (got.size() != 1 || got[0] !== 17'h11122) begin
      failures++;
      $display("FAIL after_reset_fixed size=%0d want single element 11122", got.size());
    end
  endtask

  task automatic test_width12();
    logic [7:0] bytes [3] = '{8'h01, 8'hBC, 8'hFA};
    int n = 0;
    for (int k = 0; k < 3; k++) begin
      rx_data12 = bytes[k];
      rx_valid12 = 1'b1;
      while (!rx_ready12 && n < 100) begin
        @(negedge clk);
        n++;
      end
      @(negedge clk);
    end
    rx_valid12 = 1'b0;
    while (!elem_valid12 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (elem_valid12 !== 1'b1 || elem_data12 !== 12'hABC || elem_last12 !== 1'b1) begin
      failures++;
      $display("FAIL w12_elem valid=%b data=%h last=%b want 1 abc 1", elem_valid12, elem_data12, elem_last12);
    end
    @(negedge clk);
    checks++;
    if (busy12 !== 1'b0 || rx_ready12 !== 1'b1 || err12 !== 1'b0) begin
      failures++;
      $display("FAIL w12_idle busy=%b rdy=%b err=%b want 0 1 0", busy12, rx_ready12, err12);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bad_headers();
    test_backpressure();
    test_max();
    test_random();
    test_reset_mid();
    test_width12();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sort_frame_loader.md
# sort_frame_loader

Front-end framing stage of the sorting accelerator on the ULX3S build. Consumes the byte stream from the UART receiver, decodes a length-prefixed frame, and assembles little-endian multi-byte elements. It presents the elements one at a time, with a last-element marker, to the sort core input over a valid/ready handshake. Malformed headers are rejected with a one-cycle error pulse and never reach the sorter.

## Interface
- DATA_WIDTH, 16: element width in bits; BYTES_PER_ELEM = ceil(DATA_WIDTH/8); legal range 8..32.
- MAX_ELEMS, 16: largest accepted frame length; legal range 1..255.
- clk_i  in  1  system clock; the block uses one clock.
- rst_i  in  1  reset, asynchronous and active-high.
- rx_data_i  in  8  byte from the UART receiver.
- rx_valid_i  in  1  rx_data_i holds a byte.
- rx_ready_o  out  1  loader accepts a byte this cycle.
- elem_data_o  out  DATA_WIDTH  assembled element.
- elem_valid_o  out  1  elem_data_o is valid.
- elem_last_o  out  1  final element of the frame; qualified by elem_valid_o.
- elem_ready_i  in  1  sort core accepts the element.
- busy_o  out  1  a frame is in progress (state is not IDLE).
- frame_err_o  out  1  one-cycle pulse when a header is rejected.

## Operation
- Byte transfer: rx_valid_i & rx_ready_o. Element transfer: elem_valid_o & elem_ready_i.
- State machine:
  - IDLE: rx_ready_o=1. An accepted byte is the header N.
    - N in 1..MAX_ELEMS: latch N into the remaining-count register, clear the byte counter, go to ASSEMBLE.
    - N=0 or N>MAX_ELEMS: pulse frame_err_o for one cycle and stay in IDLE. The byte is consumed.
  - ASSEMBLE: rx_ready_o=1. Accepted byte k (0-based) is written to elem bits [8k+7:8k], least significant byte first. Bits above DATA_WIDTH in the top byte are discarded.
    - On byte BYTES_PER_ELEM-1: go to EMIT, set elem_valid_o. elem_last_o = (remaining == 1).
  - EMIT: rx_ready_o=0. elem_data_o, elem_valid_o and elem_last_o hold stable until accepted.
    - On element transfer: decrement remaining. If last, go to IDLE; otherwise go to ASSEMBLE with the byte counter cleared.
- The assembly register is cleared at the start of every element, so no stale bits carry over.
- Widths: byte counter is clog2(BYTES_PER_ELEM+1) bits; remaining-count register is 8 bits. Neither counter can wrap, because N ≤ MAX_ELEMS ≤ 255.
- There is no inter-byte timeout. A truncated frame stalls in ASSEMBLE until bytes arrive or reset is applied.

## Timing
- Reset values (applied asynchronously): state=IDLE, rx_ready_o=1, elem_valid_o=0, elem_last_o=0, elem_data_o=0, busy_o=0, frame_err_o=0, all counters 0.
- Reset released mid-frame: the partial frame is discarded. The first byte accepted after release is treated as a header.
- Output latency: elem_valid_o rises on the clock edge that accepts the final byte of an element, so it is visible in the next cycle.
- frame_err_o asserts in the cycle after the bad header is accepted, for exactly one cycle.
- Back-to-back headers arriving in IDLE are each evaluated independently.
- elem_ready_i held high: one element is produced every BYTES_PER_ELEM+1 cycles. That is BYTES_PER_ELEM byte cycles plus one EMIT cycle.
- elem_ready_i low in EMIT: hold all element outputs. rx_ready_o stays 0, and no bytes are lost.
- elem_ready_i asserted outside EMIT: ignored.
- rx_valid_i while rx_ready_o=0: no byte is consumed. The upstream source must hold the byte.
- Last element accepted: return to IDLE. rx_ready_o=1 in the following cycle, and busy_o falls in that same cycle.
- All outputs are registered; there is no combinational path from rx_*_i or elem_ready_i to any output.

## Test plan
- Single frame, DATA_WIDTH=16: bytes 0x02,0x34,0x12,0xCD,0xAB with elem_ready_i=1 -> elements 0x1234 (last=0) then 0xABCD (last=1). busy_o falls after the second transfer.
- Bad headers: bytes 0x00 then 0x11 (MAX_ELEMS=16) -> two frame_err_o pulses, no elem_valid_o, state stays IDLE. A following 0x01,0xFF,0x00 -> element 0x00FF with last=1.
- Backpressure: hold elem_ready_i=0 for 5 cycles in EMIT while rx_valid_i=1 -> rx_ready_o=0 throughout, element held stable, and no byte dropped after release.
- Maximum frame: header 0x10 followed by 16 incrementing elements 0x0000..0x000F -> 16 transfers in order, elem_last_o only on 0x000F.
- Reset mid-frame: assert rst_i after header 0x03 and one data byte -> outputs return to reset values immediately. The next bytes 0x01,0x22,0x11 -> element 0x1122 with last=1.
- DATA_WIDTH=12 variant: bytes 0x01,0xBC,0xFA -> element 0xABC; the upper nibble 0xF is discarded.
